// File: rtl/bp_me_pkg.sv
// Shared types and constants for the DDR bring-up controller.
package bp_me_pkg;

  localparam int bp_ddr_cfg_bytes_gp = 12;

  typedef enum logic [2:0] {
    e_idle  = 3'd0,
    e_reset = 3'd1,
    e_calib = 3'd2,
    e_ready = 3'd3,
    e_error = 3'd4
  } bp_ddr_init_state_e;

endpackage

// File: rtl/bsg_popcount.sv
// Counts set bits of a vector; output is wide enough for the all-ones case.
module bsg_popcount #(
  parameter int width_p = 1
) (
  input  logic [width_p-1:0]             i,
  output logic [$clog2(width_p+1)-1:0]   o
);

  localparam int w_lp = $clog2(width_p + 1);

  always_comb begin
    o = '0;
    for (int k = 0; k < width_p; k++) begin
      o = o + w_lp'(i[k]);
    end
  end

endmodule

// File: rtl/bp_ddr_init_ctrl.sv
// DDR controller bring-up sequencer: holds the DMC in reset, waits for calibration,
// then opens the DMA gate; config bytes are writable only while the DMC is held.
module bp_ddr_init_ctrl
  import bp_me_pkg::*;
#(
  parameter int num_dma_p       = 1,
  parameter int reset_cycles_p  = 16,
  parameter int calib_timeout_p = 4096
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic                              cfg_w_v_i,
  input  logic [3:0]                        cfg_addr_i,
  input  logic [7:0]                        cfg_data_i,
  output logic                              cfg_ready_o,
  output logic [8*bp_ddr_cfg_bytes_gp-1:0]  dmc_cfg_o,
  output logic                              sys_reset_o,
  input  logic                              init_calib_complete_i,
  input  logic [num_dma_p-1:0]              dma_pkt_v_i,
  output logic [num_dma_p-1:0]              dma_pkt_v_o,
  input  logic [num_dma_p-1:0]              dma_pkt_yumi_i,
  output logic [num_dma_p-1:0]              dma_pkt_yumi_o,
  output logic [2:0]                        state_o,
  output logic                              error_o,
  output logic [31:0]                       pkt_count_o
);

  localparam int pop_w_lp = $clog2(num_dma_p + 1);

  bp_ddr_init_state_e r_state, w_state_next;
  logic [31:0]        r_cnt, w_cnt_next;
  logic [31:0]        r_pkt_count;
  logic               w_sys_reset, w_cfg_ready, w_gate_open, w_error;
  logic               w_cfg_we;
  logic [pop_w_lp-1:0] w_yumi_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // One shared counter: reset hold counts down, calibration wait counts up.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sys_reset  = 1'b1;
    w_cfg_ready  = 1'b0;
    w_gate_open  = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      e_idle: begin
        w_cfg_ready = 1'b1;
        if (start_i) begin
          w_state_next = e_reset;
          w_cnt_next   = 32'(reset_cycles_p - 1);
        end
      end
      e_reset: begin
        if (r_cnt == '0) begin
          w_state_next = e_calib;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 32'd1;
        end
      end
      e_calib: begin
        w_sys_reset = 1'b0;
        if (init_calib_complete_i) begin
          w_state_next = e_ready;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
          if ((r_cnt + 32'd1) == 32'(calib_timeout_p)) begin
            w_state_next = e_error;
          end
        end
      end
      e_ready: begin
        w_sys_reset = 1'b0;
        w_gate_open = 1'b1;
        if (!init_calib_complete_i) begin
          w_state_next = e_error;
        end
      end
      e_error: begin
        w_error     = 1'b1;
        w_cfg_ready = 1'b1;
        if (start_i) begin
          w_state_next = e_reset;
          w_cnt_next   = 32'(reset_cycles_p - 1);
        end
      end
      default: begin
        w_state_next = e_idle;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_cfg_we = cfg_w_v_i & w_cfg_ready;

  // Addresses past the last byte match no slot, so they are acked and dropped.
  genvar gi;
  generate
    for (gi = 0; gi < bp_ddr_cfg_bytes_gp; gi++) begin : g_cfg
      logic [7:0] r_byte;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_byte <= '0;
        end else if (w_cfg_we && (cfg_addr_i == 4'(gi))) begin
          r_byte <= cfg_data_i;
        end
      end
      assign dmc_cfg_o[8*gi +: 8] = r_byte;
    end
  endgenerate

  assign dma_pkt_v_o    = w_gate_open ? dma_pkt_v_i    : '0;
  assign dma_pkt_yumi_o = w_gate_open ? dma_pkt_yumi_i : '0;

  bsg_popcount #(
    .width_p (num_dma_p)
  ) yumi_popcount (
    .i (dma_pkt_yumi_o),
    .o (w_yumi_cnt)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pkt_count <= '0;
    end else begin
      r_pkt_count <= r_pkt_count + 32'(w_yumi_cnt);
    end
  end

  assign cfg_ready_o = w_cfg_ready;
  assign sys_reset_o = w_sys_reset;
  assign error_o     = w_error;
  assign state_o     = r_state;
  assign pkt_count_o = r_pkt_count;

endmodule

// File: tb/tb_bp_ddr_init_ctrl.sv
// Directed bench for bp_ddr_init_ctrl with 8-cycle reset hold, 100-cycle timeout, 2 DMA ports.
module tb_bp_ddr_init_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_CALIB = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        cfg_w_v_i;
  logic [3:0]  cfg_addr_i;
  logic [7:0]  cfg_data_i;
  logic        cfg_ready_o;
  logic [95:0] dmc_cfg_o;
  logic        sys_reset_o;
  logic        init_calib_complete_i;
  logic [1:0]  dma_pkt_v_i, dma_pkt_v_o, dma_pkt_yumi_i, dma_pkt_yumi_o;
  logic [2:0]  state_o;
  logic        error_o;
  logic [31:0] pkt_count_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic gate_leak = 1'b0;
  int   n;

  bp_ddr_init_ctrl #(
    .num_dma_p       (2),
    .reset_cycles_p  (8),
    .calib_timeout_p (100)
  ) dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .start_i               (start_i),
    .cfg_w_v_i             (cfg_w_v_i),
    .cfg_addr_i            (cfg_addr_i),
    .cfg_data_i            (cfg_data_i),
    .cfg_ready_o           (cfg_ready_o),
    .dmc_cfg_o             (dmc_cfg_o),
    .sys_reset_o           (sys_reset_o),
    .init_calib_complete_i (init_calib_complete_i),
    .dma_pkt_v_i           (dma_pkt_v_i),
    .dma_pkt_v_o           (dma_pkt_v_o),
    .dma_pkt_yumi_i        (dma_pkt_yumi_i),
    .dma_pkt_yumi_o        (dma_pkt_yumi_o),
    .state_o               (state_o),
    .error_o               (error_o),
    .pkt_count_o           (pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  // Called at a negedge; one config write occupies exactly one clock edge.
  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    cfg_w_v_i  = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = data;
    #1 chk("cfg_ready", 96'(cfg_ready_o), 96'(1'b1));
    @(negedge clk_i);
    cfg_w_v_i = 1'b0;
  endtask

  // Counts negedges spent in state st (bounded); flags any gate leakage seen.
  task automatic count_state(input logic [2:0] st, output int cnt);
    cnt = 0;
    while (state_o == st && cnt < 500) begin
      if (dma_pkt_v_o != 2'b00 || dma_pkt_yumi_o != 2'b00) gate_leak = 1'b1;
      cnt++;
      @(negedge clk_i);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    cfg_w_v_i = 1'b0;
    cfg_addr_i = '0;
    cfg_data_i = '0;
    init_calib_complete_i = 1'b0;
    dma_pkt_v_i = 2'b00;
    dma_pkt_yumi_i = 2'b00;
    repeat (2) @(negedge clk_i);
    chk("rst_state",     96'(state_o),     96'(S_IDLE));
    chk("rst_sys_reset", 96'(sys_reset_o), 96'(1'b1));
    chk("rst_dmc_cfg",   dmc_cfg_o,        96'h0);
    chk("rst_pkt_count", 96'(pkt_count_o), 96'h0);
    chk("rst_error",     96'(error_o),     96'(1'b0));
    reset_i = 1'b0;
    @(negedge clk_i);

    // Config writes in idle, including a discarded out-of-range address.
    cfg_write(4'd3, 8'hA5);
    cfg_write(4'd13, 8'hFF);
    chk("cfg_addr3", dmc_cfg_o, 96'h0000_0000_0000_0000_A500_0000);
    cfg_write(4'd0, 8'h11);
    cfg_write(4'd11, 8'h5C);
    chk("cfg_edges", dmc_cfg_o, 96'h5C00_0000_0000_0000_A500_0011);

    // Start together with a config write: both take effect.
    dma_pkt_v_i = 2'b11;
    #1 chk("idle_gate_v", 96'(dma_pkt_v_o), 96'(2'b00));
    @(negedge clk_i);
    start_i = 1'b1;
    cfg_w_v_i = 1'b1;
    cfg_addr_i = 4'd5;
    cfg_data_i = 8'h77;
    @(negedge clk_i);
    start_i = 1'b0;
    cfg_w_v_i = 1'b0;
    chk("start_state", 96'(state_o), 96'(S_RESET));
    chk("start_cfg",   dmc_cfg_o, 96'h5C00_0000_0000_7700_A500_0011);
    count_state(S_RESET, n);
    chk("reset_len", 96'(n), 96'd8);
    chk("calib_state",     96'(state_o),     96'(S_CALIB));
    chk("calib_sys_reset", 96'(sys_reset_o), 96'(1'b0));
    chk("calib_cfg_ready", 96'(cfg_ready_o), 96'(1'b0));

    // Config write while calibrating must be ignored.
    cfg_w_v_i = 1'b1;
    cfg_addr_i = 4'd0;
    cfg_data_i = 8'hFF;
    @(negedge clk_i);
    cfg_w_v_i = 1'b0;
    chk("calib_cfg_blocked", dmc_cfg_o, 96'h5C00_0000_0000_7700_A500_0011);

    // Calibration never completes: 100 cycles in calib, then error.
    count_state(S_CALIB, n);
    chk("calib_timeout", 96'(n + 1), 96'd100);
    chk("err_state",     96'(state_o),     96'(S_ERROR));
    chk("err_flag",      96'(error_o),     96'(1'b1));
    chk("err_sys_reset", 96'(sys_reset_o), 96'(1'b1));
    chk("err_cfg_ready", 96'(cfg_ready_o), 96'(1'b1));
    chk("err_gate_v",    96'(dma_pkt_v_o), 96'(2'b00));
    chk("gate_leak_1",   96'(gate_leak),   96'(1'b0));

    // Retry from error, calibration completes after 3 cycles.
    pulse_start();
    count_state(S_RESET, n);
    chk("retry_reset_len", 96'(n), 96'd8);
    repeat (2) @(negedge clk_i);
    chk("calib_gate_v", 96'(dma_pkt_v_o), 96'(2'b00));
    init_calib_complete_i = 1'b1;
    @(negedge clk_i);
    chk("ready_state",  96'(state_o),     96'(S_READY));
    chk("ready_gate_v", 96'(dma_pkt_v_o), 96'(2'b11));
    chk("ready_error",  96'(error_o),     96'(1'b0));
    chk("gate_leak_2",  96'(gate_leak),   96'(1'b0));

    // Five cycles of double yumi, then one single yumi.
    dma_pkt_yumi_i = 2'b11;
    #1 chk("ready_yumi", 96'(dma_pkt_yumi_o), 96'(2'b11));
    repeat (5) @(negedge clk_i);
    dma_pkt_yumi_i = 2'b00;
    chk("pkt_count_10", 96'(pkt_count_o), 96'd10);
    dma_pkt_yumi_i = 2'b01;
    @(negedge clk_i);
    dma_pkt_yumi_i = 2'b00;
    chk("pkt_count_11", 96'(pkt_count_o), 96'd11);

    // Calibration drop closes the gate on the next cycle.
    init_calib_complete_i = 1'b0;
    @(negedge clk_i);
    dma_pkt_yumi_i = 2'b11;
    #1;
    chk("drop_state",  96'(state_o),        96'(S_ERROR));
    chk("drop_gate_v", 96'(dma_pkt_v_o),    96'(2'b00));
    chk("drop_gate_y", 96'(dma_pkt_yumi_o), 96'(2'b00));
    @(negedge clk_i);
    dma_pkt_yumi_i = 2'b00;
    chk("drop_pkt_hold", 96'(pkt_count_o), 96'd11);

    // Second retry with calibration already high; count survives retry.
    init_calib_complete_i = 1'b1;
    pulse_start();
    count_state(S_RESET, n);
    chk("retry2_reset_len", 96'(n), 96'd8);
    @(negedge clk_i);
    chk("retry2_ready", 96'(state_o),     96'(S_READY));
    chk("retry2_pkt",   96'(pkt_count_o), 96'd11);

    // Asynchronous reset mid-ready, sampled before any clock edge.
    dma_pkt_yumi_i = 2'b11;
    #2 reset_i = 1'b1;
    #1;
    chk("areset_state",  96'(state_o),        96'(S_IDLE));
    chk("areset_sysrst", 96'(sys_reset_o),    96'(1'b1));
    chk("areset_gate_v", 96'(dma_pkt_v_o),    96'(2'b00));
    chk("areset_gate_y", 96'(dma_pkt_yumi_o), 96'(2'b00));
    chk("areset_cfg",    dmc_cfg_o,           96'h0);
    chk("areset_pkt",    96'(pkt_count_o),    96'h0);
    chk("areset_error",  96'(error_o),        96'(1'b0));
    @(negedge clk_i);
    reset_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
